video_mixer_pipe: RTL and testbench

Parametrised, fully registered final video stage for arcade cores. It takes core RGB at configurable depth with sync and blanking, and applies scanline dimming with optional per-field phase alternation and blank forcing. It optionally converts to YPbPr in limited or full range, then truncates to the DAC width. It also generates 1x/2x pixel clock enables for downstream scan doubling and OSD logic, and sits between the core video output and the board DAC pins.

---
 rtl/video_mixer_pkg.sv | 16 +
 rtl/rgb2ypbpr_pipe.sv | 63 ++++++
 rtl/video_mixer_pipe.sv | 119 +++++++++++
 tb/tb_video_mixer_pipe.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/video_mixer_pkg.sv
// video_mixer_pkg: shared constants, scanline type and the stage-3 range mapping for video_mixer_pipe
package video_mixer_pkg;
  localparam int C_YR = 66, C_YG = 129, C_YB = 25;
  localparam int C_PBR = 38, C_PBG = 74, C_PBB = 112;
  localparam int C_PRR = 112, C_PRG = 94, C_PRB = 18;
  localparam int OFF_Y = 4096, OFF_C = 32768;
  localparam int LIM_LO = 16, LIM_Y = 235, LIM_C = 240, FULL_MUL = 73;
  typedef enum logic [1:0] {SL_NONE, SL_25, SL_50, SL_75} scanline_t;
  function automatic int range_map(int sum, int s, int hi, logic full, int maxv);
    int v;
    v = sum >>> 8;
    v = v < LIM_LO * s ? LIM_LO * s : v > hi * s ? hi * s : v;
    if (full) v = ((v - LIM_LO * s) * FULL_MUL) >>> 6;
    return v > maxv ? maxv : v;
  endfunction
endpackage

// File: rtl/rgb2ypbpr_pipe.sv
// rgb2ypbpr_pipe: colour stages 2-3; YPbPr conversion when VIDEO_MIXER_PIPE_YPBPR_EN is defined, else a 2-clock delay
module rgb2ypbpr_pipe import video_mixer_pkg::*; #(
  parameter int IN_BITS = 8,
  parameter int OUT_BITS = 6
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                vld,
  input  logic                ypbpr,
  input  logic                ypbpr_full,
  input  logic [IN_BITS-1:0]  r,
  input  logic [IN_BITS-1:0]  g,
  input  logic [IN_BITS-1:0]  b,
  output logic [OUT_BITS-1:0] r_o,
  output logic [OUT_BITS-1:0] g_o,
  output logic [OUT_BITS-1:0] b_o
);
  localparam int SH = IN_BITS - OUT_BITS;
  logic [3*IN_BITS-1:0] rgb2_q, rgb2_d;
  logic [3*OUT_BITS-1:0] out_q, out_d;
  logic vld2_q, vld2_d;
  logic [OUT_BITS-1:0] pass_r, pass_g, pass_b;
  always_comb begin
    rgb2_d = {r, g, b};
    vld2_d = vld;
    pass_r = OUT_BITS'(rgb2_q[3*IN_BITS-1 -: IN_BITS] >> SH);
    pass_g = OUT_BITS'(rgb2_q[2*IN_BITS-1 -: IN_BITS] >> SH);
    pass_b = OUT_BITS'(rgb2_q[IN_BITS-1:0] >> SH);
  end
`ifdef VIDEO_MIXER_PIPE_YPBPR_EN
  localparam int S = 1 << (IN_BITS - 8);
  localparam int W = IN_BITS + 11;
  localparam int MAXV = (1 << IN_BITS) - 1;
  logic signed [W-1:0] y2_q, pb2_q, pr2_q, y2_d, pb2_d, pr2_d;
  always_comb begin
    y2_d  = W'(OFF_Y * S + C_YR * int'(r) + C_YG * int'(g) + C_YB * int'(b));
    pb2_d = W'(OFF_C * S - C_PBR * int'(r) - C_PBG * int'(g) + C_PBB * int'(b));
    pr2_d = W'(OFF_C * S + C_PRR * int'(r) - C_PRG * int'(g) - C_PRB * int'(b));
    out_d = !vld2_q ? '0 : !ypbpr ? {pass_r, pass_g, pass_b} :
            {OUT_BITS'(range_map(int'(pr2_q), S, LIM_C, ypbpr_full, MAXV) >>> SH),
             OUT_BITS'(range_map(int'(y2_q), S, LIM_Y, ypbpr_full, MAXV) >>> SH),
             OUT_BITS'(range_map(int'(pb2_q), S, LIM_C, ypbpr_full, MAXV) >>> SH)};
  end
  always_ff @(posedge clk_sys)
    if (reset) {y2_q, pb2_q, pr2_q} <= '0;
    else {y2_q, pb2_q, pr2_q} <= {y2_d, pb2_d, pr2_d};
`else
  logic unused_mode;
  assign unused_mode = ypbpr ^ ypbpr_full;
  always_comb out_d = vld2_q ? {pass_r, pass_g, pass_b} : '0;
`endif
  always_ff @(posedge clk_sys)
    if (reset) begin
      rgb2_q <= '0;
      vld2_q <= 1'b0;
      out_q <= '0;
    end else begin
      rgb2_q <= rgb2_d;
      vld2_q <= vld2_d;
      out_q <= out_d;
    end
  assign {r_o, g_o, b_o} = out_q;
endmodule

// File: rtl/video_mixer_pipe.sv
// video_mixer_pipe: final video stage (CE gen, scanlines, sync encode); YPbPr path needs VIDEO_MIXER_PIPE_YPBPR_EN
module video_mixer_pipe import video_mixer_pkg::*; #(
  parameter int IN_BITS = 8,
  parameter int OUT_BITS = 6,
  parameter int CNT_BITS = 8
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                pix_ce,
  input  logic [1:0]          scanlines,
  input  logic                field_alt,
  input  logic                ypbpr,
  input  logic                ypbpr_full,
  input  logic                csync,
  input  logic [IN_BITS-1:0]  R,
  input  logic [IN_BITS-1:0]  G,
  input  logic [IN_BITS-1:0]  B,
  input  logic                HSync,
  input  logic                VSync,
  input  logic                HBlank,
  input  logic                VBlank,
  output logic [OUT_BITS-1:0] VGA_R,
  output logic [OUT_BITS-1:0] VGA_G,
  output logic [OUT_BITS-1:0] VGA_B,
  output logic                VGA_HS,
  output logic                VGA_VS,
  output logic                ce_x1,
  output logic                ce_x2
);
  logic [CNT_BITS-1:0] cnt_q, cnt_d, pixsz_q, pixsz_d;
  logic pce_q, pce_d, ce1_q, ce1_d, ce2_q, ce2_d, rise;
  logic hs_q, hs_d, vs_q, vs_d, line_q, line_d, field_q, field_d, hs_fall, vs_fall;
  logic [3*IN_BITS-1:0] rgb1_q, rgb1_d;
  logic hs1_q, hs1_d, vs1_q, vs1_d, vld1_q, vld1_d;
  logic hs2_q, hs2_d, vs2_q, vs2_d, vhs_q, vhs_d, vvs_q, vvs_d, comp;
  scanline_t sl;
  function automatic logic [IN_BITS-1:0] dim(logic [IN_BITS-1:0] x, scanline_t s);
    return s == SL_25 ? (x >> 1) + (x >> 2) : s == SL_50 ? x >> 1 : s == SL_75 ? x >> 2 : x;
  endfunction
  always_comb begin
    rise = pix_ce & ~pce_q;
    pce_d = pix_ce;
    cnt_d = rise ? '0 : &cnt_q ? cnt_q : cnt_q + CNT_BITS'(1);
    pixsz_d = rise ? cnt_q >> 1 : pixsz_q;
    ce1_d = rise;
    ce2_d = rise | ((cnt_q == pixsz_q) && (pixsz_q != '0));
    hs_fall = hs_q & ~HSync;
    vs_fall = vs_q & ~VSync;
    hs_d = HSync;
    vs_d = VSync;
    field_d = vs_fall ? field_alt & ~field_q : field_q;
    line_d = vs_fall ? field_d : hs_fall ? ~line_q : line_q;
    sl = scanline_t'(scanlines);
    rgb1_d = (HBlank | VBlank) ? '0 : line_q ? {dim(R, sl), dim(G, sl), dim(B, sl)} : {R, G, B};
    hs1_d = HSync;
    vs1_d = VSync;
    vld1_d = 1'b1;
    hs2_d = hs1_q;
    vs2_d = vs1_q;
    comp = ypbpr | csync;
    vhs_d = comp ? ~(hs2_q ^ vs2_q) : ~hs2_q;
    vvs_d = comp | ~vs2_q;
  end
  always_ff @(posedge clk_sys)
    if (reset) begin
      cnt_q <= '0;
      pixsz_q <= '0;
      pce_q <= 1'b0;
      ce1_q <= 1'b0;
      ce2_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      line_q <= 1'b0;
      field_q <= 1'b0;
      rgb1_q <= '0;
      hs1_q <= 1'b0;
      vs1_q <= 1'b0;
      vld1_q <= 1'b0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
      vhs_q <= 1'b1;
      vvs_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      pixsz_q <= pixsz_d;
      pce_q <= pce_d;
      ce1_q <= ce1_d;
      ce2_q <= ce2_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      line_q <= line_d;
      field_q <= field_d;
      rgb1_q <= rgb1_d;
      hs1_q <= hs1_d;
      vs1_q <= vs1_d;
      vld1_q <= vld1_d;
      hs2_q <= hs2_d;
      vs2_q <= vs2_d;
      vhs_q <= vhs_d;
      vvs_q <= vvs_d;
    end
  rgb2ypbpr_pipe #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_conv (
    .clk_sys(clk_sys),
    .reset(reset),
    .vld(vld1_q),
    .ypbpr(ypbpr),
    .ypbpr_full(ypbpr_full),
    .r(rgb1_q[3*IN_BITS-1 -: IN_BITS]),
    .g(rgb1_q[2*IN_BITS-1 -: IN_BITS]),
    .b(rgb1_q[IN_BITS-1:0]),
    .r_o(VGA_R),
    .g_o(VGA_G),
    .b_o(VGA_B)
  );
  assign VGA_HS = vhs_q;
  assign VGA_VS = vvs_q;
  assign ce_x1 = ce1_q;
  assign ce_x2 = ce2_q;
endmodule

// File: tb/tb_video_mixer_pipe.sv
// tb_video_mixer_pipe: scoreboard bench, expected pixels queued at drive time and compared 3 clocks later
module tb_video_mixer_pipe;
  typedef struct packed {
    logic [5:0] r, g, b;
    logic hs, vs;
    logic chk;
  } exp_t;
  exp_t q[$];
  logic clk_sys = 1'b0, reset = 1'b1, pix_ce = 1'b0;
  logic [1:0] scanlines = 2'd0;
  logic field_alt = 1'b0, ypbpr = 1'b0, ypbpr_full = 1'b0, csync = 1'b0;
  logic [7:0] R = 8'd0, G = 8'd0, B = 8'd0;
  logic HSync = 1'b0, VSync = 1'b0, HBlank = 1'b0, VBlank = 1'b0;
  logic [5:0] VGA_R, VGA_G, VGA_B;
  logic VGA_HS, VGA_VS, ce_x1, ce_x2;
  int errors = 0, checks = 0, k = 0, rises = 0, since = 0;
  bit ce_auto = 1'b0, line_m = 1'b0, field_m = 1'b0, hsp_m = 1'b0, vsp_m = 1'b0, pcep_m = 1'b0;
  always #5 clk_sys = ~clk_sys;
  video_mixer_pipe #(.IN_BITS(8), .OUT_BITS(6), .CNT_BITS(8)) dut (
    .clk_sys(clk_sys), .reset(reset), .pix_ce(pix_ce), .scanlines(scanlines),
    .field_alt(field_alt), .ypbpr(ypbpr), .ypbpr_full(ypbpr_full), .csync(csync),
    .R(R), .G(G), .B(B), .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .ce_x1(ce_x1), .ce_x2(ce_x2)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  function automatic int dimm(int x);
    if (HBlank || VBlank) return 0;
    if (!line_m) return x;
    case (scanlines)
      2'd1: return x / 2 + x / 4;
      2'd2: return x / 2;
      2'd3: return x / 4;
      default: return x;
    endcase
  endfunction
`ifdef VIDEO_MIXER_PIPE_YPBPR_EN
  function automatic int lim(int sum, int hi);
    int v;
    v = sum / 256;
    if (v < 16) v = 16;
    if (v > hi) v = hi;
    if (ypbpr_full) begin
      v = (v - 16) * 73 / 64;
      if (v > 255) v = 255;
    end
    return v;
  endfunction
`endif
  function automatic exp_t expect_now();
    exp_t e;
    int r8, g8, b8;
    bit comp;
    r8 = dimm(int'(R));
    g8 = dimm(int'(G));
    b8 = dimm(int'(B));
    e.r = 6'(r8 / 4);
    e.g = 6'(g8 / 4);
    e.b = 6'(b8 / 4);
`ifdef VIDEO_MIXER_PIPE_YPBPR_EN
    if (ypbpr) begin
      e.r = 6'(lim(32768 + 112 * r8 - 94 * g8 - 18 * b8, 240) / 4);
      e.g = 6'(lim(4096 + 66 * r8 + 129 * g8 + 25 * b8, 235) / 4);
      e.b = 6'(lim(32768 - 38 * r8 - 74 * g8 + 112 * b8, 240) / 4);
    end
`endif
    comp = ypbpr | csync;
    e.hs = comp ? !(HSync ^ VSync) : !HSync;
    e.vs = comp ? 1'b1 : !VSync;
    e.chk = 1'b1;
    return e;
  endfunction
  task automatic cyc();
    exp_t e;
    if (ce_auto) pix_ce = (k % 8 == 0);
    k++;
    q.push_back(expect_now());
    @(posedge clk_sys);
    if (vsp_m && !VSync) begin
      field_m = field_alt ? !field_m : 1'b0;
      line_m = field_m;
    end else if (hsp_m && !HSync) line_m = !line_m;
    hsp_m = HSync;
    vsp_m = VSync;
    if (pix_ce && !pcep_m) begin
      rises++;
      since = 0;
    end else since++;
    pcep_m = pix_ce;
    @(negedge clk_sys);
    e = q.pop_front();
    if (e.chk) begin
      chk("vga_r", VGA_R, e.r);
      chk("vga_g", VGA_G, e.g);
      chk("vga_b", VGA_B, e.b);
      chk("vga_hs", VGA_HS, e.hs);
      chk("vga_vs", VGA_VS, e.vs);
    end
    if (ce_auto) begin
      chk("ce_x1", ce_x1, rises > 0 && since == 0);
      if (rises != 1) chk("ce_x2", ce_x2, rises > 1 && (since == 0 || since == 4));
    end
  endtask
  task automatic do_reset(int n);
    exp_t z;
    reset = 1'b1;
    pix_ce = 1'b0;
    repeat (n) begin
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("rst_r", VGA_R, 0);
      chk("rst_g", VGA_G, 0);
      chk("rst_b", VGA_B, 0);
      chk("rst_hs", VGA_HS, 1);
      chk("rst_vs", VGA_VS, 1);
      chk("rst_ce_x1", ce_x1, 0);
      chk("rst_ce_x2", ce_x2, 0);
    end
    reset = 1'b0;
    z = '{r: 6'd0, g: 6'd0, b: 6'd0, hs: 1'b1, vs: 1'b1, chk: 1'b1};
    q.delete();
    q.push_back(z);
    q.push_back(z);
    line_m = 0; field_m = 0; hsp_m = 0; vsp_m = 0; pcep_m = 0;
    rises = 0; since = 0;
  endtask
  task automatic set_mode(logic yp, logic full, logic cs);
    ypbpr = yp;
    ypbpr_full = full;
    csync = cs;
    foreach (q[i]) q[i].chk = 1'b0;
  endtask
  task automatic hline(int n, int r, int g, int b);
    HBlank = 1; HSync = 1;
    repeat (2) cyc();
    HSync = 0;
    cyc();
    HBlank = 0; R = 8'(r); G = 8'(g); B = 8'(b);
    repeat (n) cyc();
  endtask
  task automatic vsync_pulse();
    HBlank = 1; VBlank = 1; HSync = 1; VSync = 1;
    repeat (2) cyc();
    HSync = 0; VSync = 0;
    cyc();
    VBlank = 0;
  endtask
  initial begin
    int n1, n2, p2;
    do_reset(3);
    ce_auto = 1;
    scanlines = 2;
    vsync_pulse();
    repeat (4) hline(12, 200, 200, 200);
    scanlines = 1;
    repeat (2) hline(10, 100, 37, 255);
    scanlines = 3;
    repeat (2) hline(10, 255, 128, 7);
    scanlines = 0;
    hline(10, 9, 250, 66);
    set_mode(0, 0, 1);
    scanlines = 2;
    vsync_pulse();
    repeat (2) hline(10, 180, 60, 240);
    set_mode(0, 0, 0);
    field_alt = 1;
    repeat (3) begin
      vsync_pulse();
      repeat (3) hline(10, 200, 200, 200);
    end
    field_alt = 0;
    scanlines = 0;
    set_mode(1, 0, 0);
    hline(10, 255, 255, 255);
    hline(10, 0, 0, 0);
    hline(10, 50, 100, 150);
    vsync_pulse();
    set_mode(1, 1, 0);
    hline(10, 0, 0, 0);
    hline(10, 255, 255, 255);
    hline(10, 200, 30, 90);
    set_mode(0, 0, 0);
    scanlines = 2;
    hline(5, 120, 160, 200);
    do_reset(2);
    R = 8'd240; G = 8'd16; B = 8'd128;
    repeat (20) cyc();
    hline(10, 200, 200, 200);
    ce_auto = 0;
    pix_ce = 0;
    repeat (300) cyc();
    pix_ce = 1;
    cyc();
    pix_ce = 0;
    chk("sat_x1", ce_x1, 1);
    n1 = 0; n2 = 0; p2 = 0;
    for (int i = 1; i <= 400; i++) begin
      cyc();
      if (ce_x1) n1++;
      if (ce_x2) begin
        n2++;
        p2 = i;
      end
    end
    chk("sat_x1_none", n1, 0);
    chk("sat_x2_count", n2, 1);
    chk("sat_x2_offset", p2, 128);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
